// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing FSM: op menu, operand latch, ALU launch/wait, result display.
// Optional WAIT timeout enabled by defining CALC_SEQ_CTRL_TIMEOUT_EN.
module calc_seq_ctrl #(
  parameter int          NUM_OPS     = 4,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       enter,
  input  logic       back,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  input  logic       alu_err,
  output logic [2:0] op_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_start,
  output logic [1:0] disp_mode,
  output logic [7:0] disp_val,
  output logic       busy
);

  localparam logic [2:0] OP_MAX  = 3'(NUM_OPS - 1);
  localparam logic [1:0] DM_MENU = 2'b00;
  localparam logic [1:0] DM_BUSY = 2'b01;
  localparam logic [1:0] DM_RES  = 2'b10;
  localparam logic [1:0] DM_ERR  = 2'b11;

  typedef enum logic [1:0] {S_MENU, S_START, S_WAIT, S_RESULT} state_t;
  state_t state;

  logic [2:0] op_inc, op_dec;
  assign op_inc = (op_sel == OP_MAX) ? 3'd0 : op_sel + 3'd1;
  assign op_dec = (op_sel == 3'd0) ? OP_MAX : op_sel - 3'd1;

`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_MENU;
      op_sel    <= 3'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_start <= 1'b0;
      disp_mode <= DM_MENU;
      disp_val  <= 8'd0;
      busy      <= 1'b0;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
      tmo_cnt   <= 8'd0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_MENU: begin
          // back outranks everything; in MENU it simply swallows the cycle
          if (!back) begin
            if (enter) begin
              alu_a     <= a;
              alu_b     <= b;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              disp_mode <= DM_BUSY;
              disp_val  <= {a, b};
              state     <= S_START;
            end else if (up && !down) begin
              op_sel   <= op_inc;
              disp_val <= {5'd0, op_inc};
            end else if (down && !up) begin
              op_sel   <= op_dec;
              disp_val <= {5'd0, op_dec};
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
          tmo_cnt <= 8'd0;
`endif
        end
        S_WAIT: begin
          if (back) begin
            busy      <= 1'b0;
            disp_mode <= DM_MENU;
            disp_val  <= {5'd0, op_sel};
            state     <= S_MENU;
          end else if (alu_done) begin
            busy      <= 1'b0;
            disp_mode <= alu_err ? DM_ERR : DM_RES;
            disp_val  <= alu_err ? 8'hEE : alu_result;
            state     <= S_RESULT;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
          end else if (tmo_cnt == TIMEOUT_CYC - 8'd1) begin
            // last allowed WAIT cycle expired with no result
            busy      <= 1'b0;
            disp_mode <= DM_ERR;
            disp_val  <= 8'hEE;
            state     <= S_RESULT;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        S_RESULT: begin
          if (back) begin
            disp_mode <= DM_MENU;
            disp_val  <= {5'd0, op_sel};
            state     <= S_MENU;
          end else if (enter) begin
            alu_a     <= a;
            alu_b     <= b;
            alu_start <= 1'b1;
            busy      <= 1'b1;
            disp_mode <= DM_BUSY;
            disp_val  <= {a, b};
            state     <= S_START;
          end
        end
        default: state <= S_MENU;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl; result displays are scored against a queue.
module tb_calc_seq_ctrl;

`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
  localparam logic [7:0] TCYC = 8'd10;
`else
  localparam logic [7:0] TCYC = 8'd255;
`endif

  logic       clk, rst, up, down, enter, back, alu_done, alu_err, alu_start, busy;
  logic [3:0] a, b, alu_a, alu_b;
  logic [7:0] alu_result, disp_val;
  logic [2:0] op_sel;
  logic [1:0] disp_mode;

  typedef struct {logic [1:0] mode; logic [7:0] val;} exp_t;
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  logic in_res = 1'b0;

  calc_seq_ctrl #(.NUM_OPS(4), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .enter(enter), .back(back),
    .a(a), .b(b), .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .op_sel(op_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .disp_mode(disp_mode), .disp_val(disp_val), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [7:0] v);
    exp_t e;
    e.mode = m; e.val = v;
    sbq.push_back(e);
  endtask

  // scoreboard: every entry into a result/error display must match the queue head
  always @(posedge clk) begin
    #1;
    if (rst && disp_mode[1] && !in_res) begin
      if (sbq.size() == 0) chk("sb_unexpected", sbq.size(), 1);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_mode", disp_mode, e.mode);
        chk("sb_val", disp_val, e.val);
      end
    end
    in_res = rst && disp_mode[1];
  end

  initial begin
    int n;
    logic [2:0] exp_op;
    clk = 0; rst = 0; up = 0; down = 0; enter = 0; back = 0;
    a = 0; b = 0; alu_done = 0; alu_result = 0; alu_err = 0;
    #12;
    chk("rst_op_sel", op_sel, 0);
    chk("rst_mode", disp_mode, 0);
    chk("rst_val", disp_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", alu_start, 0);
    rst = 1;
    tick;

    // op menu wrap up
    exp_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      up = 1; tick; up = 0;
      exp_op = (exp_op == 3'd3) ? 3'd0 : exp_op + 3'd1;
      chk("up_seq", op_sel, exp_op);
    end
    chk("menu_val", disp_val, 8'h01);
    down = 1; tick; down = 0;
    chk("down_to0", op_sel, 0);
    down = 1; tick; down = 0;
    chk("down_wrap", op_sel, 3);
    up = 1; down = 1; tick; up = 0; down = 0;
    chk("updown_ign", op_sel, 3);
    back = 1; up = 1; tick; back = 0; up = 0;
    chk("back_prio", op_sel, 3);
    chk("menu_val3", disp_val, 8'h03);

    // basic operation
    a = 4'h3; b = 4'h5; enter = 1; tick; enter = 0;
    chk("st_start", alu_start, 1);
    chk("st_a", alu_a, 3);
    chk("st_b", alu_b, 5);
    chk("st_val", disp_val, 8'h35);
    chk("st_busy", busy, 1);
    chk("st_mode", disp_mode, 1);
    a = 4'h9; up = 1; tick; up = 0;
    chk("wait_start0", alu_start, 0);
    chk("wait_op_frz", op_sel, 3);
    chk("wait_a_frz", alu_a, 3);
    enter = 1; tick; enter = 0;
    chk("wait_enter_ign", alu_start, 0);
    alu_done = 1; alu_result = 8'h08; push_exp(2'b10, 8'h08); tick; alu_done = 0;
    chk("res_mode", disp_mode, 2);
    chk("res_val", disp_val, 8'h08);
    chk("res_busy", busy, 0);
    up = 1; tick; up = 0;
    chk("res_hold", disp_val, 8'h08);
    chk("res_op", op_sel, 3);

    // chained op with ALU error
    a = 4'h2; b = 4'h4; enter = 1; tick; enter = 0;
    chk("ch_start", alu_start, 1);
    chk("ch_val", disp_val, 8'h24);
    tick;
    alu_done = 1; alu_err = 1; alu_result = 8'h06; push_exp(2'b11, 8'hEE); tick;
    alu_done = 0; alu_err = 0;
    chk("err_mode", disp_mode, 3);
    chk("err_val", disp_val, 8'hEE);
    back = 1; tick; back = 0;
    chk("back_mode", disp_mode, 0);
    chk("back_op", op_sel, 3);
    chk("back_val", disp_val, 8'h03);

    // abort: back beats a same-cycle result
    a = 4'h1; b = 4'h1; enter = 1; tick; enter = 0; tick;
    back = 1; alu_done = 1; alu_result = 8'h77; tick; back = 0; alu_done = 0;
    chk("abort_mode", disp_mode, 0);
    chk("abort_busy", busy, 0);
    tick;
    chk("abort_val", disp_val, 8'h03);
    alu_done = 1; alu_result = 8'h55; tick; alu_done = 0;
    chk("menu_done_ign", disp_mode, 0);

    // stuck ALU
    enter = 1; tick; enter = 0;
`ifdef CALC_SEQ_CTRL_TIMEOUT_EN
    push_exp(2'b11, 8'hEE);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (disp_mode == 2'b11) break;
      n++;
    end
    chk("tmo_cycles", n, 10);
    chk("tmo_val", disp_val, 8'hEE);
    back = 1; tick; back = 0;
`else
    n = 0;
    repeat (1000) begin
      tick;
      if (disp_mode == 2'b01) n++;
    end
    chk("no_tmo_cycles", n, 1000);
    chk("no_tmo_busy", busy, 1);
    back = 1; tick; back = 0;
`endif
    chk("stuck_exit", disp_mode, 0);

    // async reset mid-WAIT
    a = 4'hA; b = 4'hB; enter = 1; tick; enter = 0; tick;
    #2 rst = 0; #1;
    chk("arst_op", op_sel, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_mode", disp_mode, 0);
    chk("arst_val", disp_val, 0);
    chk("arst_busy", busy, 0);
    tick; tick;
    rst = 1; up = 1; tick; up = 0;
    chk("post_rst_up", op_sel, 1);
    n = 0;
    repeat (5) begin
      tick;
      if (alu_start || busy) n++;
    end
    chk("no_restart", n, 0);

    chk("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
